sys_timing_gen: RTL and testbench

Parametrised clock-enable and reset sequencer for the retro machine cores. Generates NUM_CE independent clock-enable pulse trains from clk_sys, each with a divisor selectable at run time, for turbo modes and multi-rate peripherals. It also runs the machine reset sequence: a power-on delay, then a stretched reset on any request or on PLL loss. It sits between the PLL/user_io and the CPU and hardware blocks. It replaces the hand-coded ce divider and reset process in each top level.

---
 rtl/sys_timing_gen.sv | 124 ++++++++++++
 tb/tb_sys_timing_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sys_timing_gen.sv
// Clock-enable divider bank and machine reset sequencer (power-on delay, then
// stretched reset on request or PLL loss).
module sys_timing_gen #(
   parameter int NUM_CE     = 2,
   parameter int DIV_W      = 8,
   parameter int POR_CYCLES = 20_000_000,
   parameter int STRETCH    = 15
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic                    pll_locked,
   input  logic                    reset_req,
   input  logic [NUM_CE*DIV_W-1:0] div,
   input  logic [NUM_CE-1:0]       ce_en,
   input  logic                    ce_sync,
   output logic [NUM_CE-1:0]       ce,
   output logic                    sys_reset,
   output logic                    por_done
);

   localparam int PC_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
   localparam int SC_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;
   localparam logic [PC_W-1:0] PC_INIT = PC_W'(POR_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_INIT = SC_W'(STRETCH - 1);

   localparam logic [1:0] ST_POR  = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [DIV_W-1:0] cnt_q  [NUM_CE];
   logic [DIV_W-1:0] cnt_d  [NUM_CE];
   logic [DIV_W-1:0] divl_q [NUM_CE];
   logic [DIV_W-1:0] divl_d [NUM_CE];
   logic [NUM_CE-1:0] ce_q, ce_d;

   logic [1:0]      sync_q;
   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [SC_W-1:0] sc_q, sc_d;
   logic            sysrst_q, sysrst_d;
   logic            por_q, por_d;
   logic            req;

   // Divisor is only reloaded at wrap so a mid-period change never cuts a pulse short.
   always_comb begin
      cnt_d  = cnt_q;
      divl_d = divl_q;
      ce_d   = '0;
      for (int unsigned i = 0; i < NUM_CE; i++) begin
         if (ce_sync) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == divl_q[i]) begin
            cnt_d[i]  = '0;
            divl_d[i] = div[i*DIV_W +: DIV_W];
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
         end
         ce_d[i] = (cnt_q[i] == divl_q[i]) & ce_en[i] & ~ce_sync;
      end
   end

   assign req = reset_req | ~sync_q[1];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sc_d    = sc_q;
      por_d   = por_q;
      case (state_q)
         ST_POR: begin
            if (pc_q == '0) begin
               state_d = ST_HOLD;
               por_d   = 1'b1;
            end else begin
               pc_d = pc_q - PC_W'(1);
            end
         end
         ST_HOLD: begin
            if (req)              sc_d    = SC_INIT;
            else if (sc_q == '0)  state_d = ST_RUN;
            else                  sc_d    = sc_q - SC_W'(1);
         end
         ST_RUN: begin
            if (req) begin
               state_d = ST_HOLD;
               sc_d    = SC_INIT;
            end
         end
         default: state_d = ST_POR;
      endcase
      sysrst_d = (state_d != ST_RUN);
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_CE; i++) begin
            cnt_q[i]  <= '0;
            divl_q[i] <= div[i*DIV_W +: DIV_W];
         end
         ce_q     <= '0;
         sync_q   <= '0;
         state_q  <= ST_POR;
         pc_q     <= PC_INIT;
         sc_q     <= SC_INIT;
         sysrst_q <= 1'b1;
         por_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         divl_q   <= divl_d;
         ce_q     <= ce_d;
         sync_q   <= {sync_q[0], pll_locked};
         state_q  <= state_d;
         pc_q     <= pc_d;
         sc_q     <= sc_d;
         sysrst_q <= sysrst_d;
         por_q    <= por_d;
      end
   end

   assign ce        = ce_q;
   assign sys_reset = sysrst_q;
   assign por_done  = por_q;

endmodule

// File: tb/tb_sys_timing_gen.sv
// Bench for sys_timing_gen: directed scenarios then random traffic, checked
// against an edge-scheduled model of pulse times and reset release times.
module tb_sys_timing_gen;

   localparam int NCE = 2;
   localparam int DW  = 8;
   localparam int P   = 8;
   localparam int S   = 3;

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic              pll_locked;
   logic              reset_req;
   logic [NCE*DW-1:0] div;
   logic [NCE-1:0]    ce_en;
   logic              ce_sync;
   logic [NCE-1:0]    ce;
   logic              sys_reset;
   logic              por_done;

   sys_timing_gen #(
      .NUM_CE     (NCE),
      .DIV_W      (DW),
      .POR_CYCLES (P),
      .STRETCH    (S)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .pll_locked (pll_locked),
      .reset_req  (reset_req),
      .div        (div),
      .ce_en      (ce_en),
      .ce_sync    (ce_sync),
      .ce         (ce),
      .sys_reset  (sys_reset),
      .por_done   (por_done)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;

   // Model: t = edge index since release, nxt = edge at which a channel next
   // fires, lastreq = last edge that (re)started the reset stretch.
   int t;
   int lastreq;
   int nxt [NCE];
   int dq  [NCE];
   logic p1, p2;
   logic [NCE-1:0] exp_ce;
   logic exp_rst, exp_por;

   task automatic step();
      logic ls;
      logic req;
      @(posedge clk_sys);
      if (!reset_n) begin
         t       = -1;
         lastreq = P - 1;
         p1      = 1'b0;
         p2      = 1'b0;
         for (int i = 0; i < NCE; i++) begin
            dq[i]  = int'(div[i*DW +: DW]);
            nxt[i] = dq[i];
         end
         exp_ce  = '0;
         exp_rst = 1'b1;
         exp_por = 1'b0;
      end else begin
         t++;
         ls  = p2;
         p2  = p1;
         p1  = pll_locked;
         req = reset_req | ~ls;
         if (t > P - 1 && req) lastreq = t;
         exp_rst = (t <= lastreq + S - 1);
         exp_por = (t >= P - 1);
         for (int i = 0; i < NCE; i++) begin
            exp_ce[i] = 1'b0;
            if (ce_sync) begin
               nxt[i] = t + 1 + dq[i];
            end else if (t == nxt[i]) begin
               exp_ce[i] = ce_en[i];
               dq[i]     = int'(div[i*DW +: DW]);
               nxt[i]    = t + dq[i] + 1;
            end
         end
      end
      #1;
      total++;
      assert (ce === exp_ce) else begin
         bad++;
         $error("FAIL ce t=%0d got=%b exp=%b", t, ce, exp_ce);
      end
      total++;
      assert (sys_reset === exp_rst) else begin
         bad++;
         $error("FAIL sys_reset t=%0d got=%b exp=%b", t, sys_reset, exp_rst);
      end
      total++;
      assert (por_done === exp_por) else begin
         bad++;
         $error("FAIL por_done t=%0d got=%b exp=%b", t, por_done, exp_por);
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      reset_n    = 1'b0;
      pll_locked = 1'b1;
      reset_req  = 1'b0;
      div        = {8'd0, 8'd4};
      ce_en      = 2'b11;
      ce_sync    = 1'b0;
      #2;
      run(2);

      // power-on sequence plus steady pulses
      reset_n = 1'b1;
      run(16);

      // shorten channel 0 divisor mid-period
      run(3);
      div[7:0] = 8'd1;
      run(14);

      // gate channel 1 and re-enable
      ce_en[1] = 1'b0;
      run(3);
      ce_en[1] = 1'b1;
      run(4);

      // request in RUN, then a repeat during the stretch
      reset_req = 1'b1;
      run(4);
      reset_req = 1'b0;
      run(1);
      reset_req = 1'b1;
      run(1);
      reset_req = 1'b0;
      run(6);

      // single-cycle PLL loss
      pll_locked = 1'b0;
      run(1);
      pll_locked = 1'b1;
      run(8);

      // phase alignment with div 3 and 5
      div = {8'd5, 8'd3};
      run(13);
      ce_sync = 1'b1;
      run(1);
      ce_sync = 1'b0;
      run(10);

      // reset mid-RUN reruns POR
      reset_n = 1'b0;
      run(1);
      reset_n = 1'b1;
      run(14);

      // random traffic
      repeat (600) begin
         for (int i = 0; i < NCE; i++) begin
            if ($urandom_range(0, 15) == 0) div[i*DW +: DW] = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0)  ce_en[i] = ~ce_en[i];
         end
         reset_req  = ($urandom_range(0, 19) == 0);
         pll_locked = ($urandom_range(0, 39) != 0);
         ce_sync    = ($urandom_range(0, 24) == 0);
         reset_n    = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
